// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Sits downstream of the sqrt block and feeds the seven-segment driver.
//
// Handshake: a conversion request is accepted on the rising edge where
// start=1 and the FSM is idle; bin is captured on that same edge. start while
// busy is ignored and bin is not resampled. done is a one-cycle pulse that
// marks the edge at which bcd/blank were updated. start may be asserted in the
// done cycle, because the FSM is already idle then.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   conversion request
//   bin    in   [W-1:0] unsigned value, sampled with start
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, bcd/blank just updated
//   bcd    out  [4*D-1:0] packed BCD, digit 0 in bits [3:0]
//   blank  out  [D-1:0] leading-zero blank mask, bit k blanks digit k
//
// Configuration macro: BIN2BCD_LEADING_ZERO_BLANK_EN
//   defined   -> blank is computed and registered with bcd at completion
//   undefined -> blank is tied to zero, no blanking logic is built
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int W = 21,
    parameter int D = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic [D-1:0]     blank
);

    localparam int SW = 4*D + W;   // working register: BCD digits above binary
    localparam int CW = 5;         // iteration counter width

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [SW-1:0]    r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [4*D-1:0]   r_bcd;

    logic [SW-1:0]    w_adj;
    logic [SW-1:0]    w_shift;
    logic             w_last;

    // Add-3 correction on every BCD nibble that is 5 or more, so that the
    // following shift carries correctly into the next decimal digit.
    always_comb begin
        w_adj = r_sh;
        for (int k = 0; k < D; k++) begin
            if (r_sh[W+4*k +: 4] >= 4'd5) begin
                w_adj[W+4*k +: 4] = r_sh[W+4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = w_adj << 1;

    // Counter holds the index of the iteration being performed this cycle.
    assign w_last = (r_state == S_RUN) && (r_cnt == CW'(W-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh    <= {{(4*D){1'b0}}, bin};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sh  <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd   <= w_shift[SW-1 -: 4*D];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    logic [D-1:0] r_blank;
    logic [D-1:0] w_blank_next;

    // A digit is blanked when it and every digit above it are zero. Digit 0
    // is never blanked so that a zero result still shows a single "0".
    always_comb begin
        w_blank_next        = '0;
        w_blank_next[D-1]   = (w_shift[SW-1 -: 4] == 4'd0);
        for (int k = D-2; k >= 1; k--) begin
            w_blank_next[k] = w_blank_next[k+1] && (w_shift[W+4*k +: 4] == 4'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank <= {{(D-1){1'b1}}, 1'b0};
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule
